pc_fetch: RTL

//   Program-counter fetch sequencer feeding the 32-bit D flip-flop (dff) pipeline register

---
 rtl/pc_fetch.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter fetch sequencer.
// Holds the fetch PC, steps it by 4 on each accepted handshake, reloads it on a
// branch/jump redirect, and counts accepted fetches for debug.
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   -> a misaligned redirect target loads TRAP_VECTOR and raises a
//                one-cycle misalign pulse (misalign port present).
//   undefined -> target[1:0] is cleared on load, no misalign port.

module pc_fetch #(
  parameter int          N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_ALIGN_CHECK_EN
  ,
  parameter logic [N-1:0] TRAP_VECTOR  = 32'h0000_0080
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         stall,
  input  logic         redirect,
  input  logic [N-1:0] target,
  input  logic         ready,
  output logic [N-1:0] pc_out,
  output logic [N-1:0] pc_plus4,
  output logic         valid,
  output logic [N-1:0] fetch_count
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic         misalign
`endif
);

  // Sequencer states: valid is high only in ST_FETCH.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_BUBBLE = 2'd2;

  localparam logic [N-1:0] PC_STEP    = {{(N-3){1'b0}}, 3'b100};
  localparam logic [N-1:0] COUNT_STEP = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ALIGN_MASK = ~{{(N-2){1'b0}}, 2'b11};

  // True when the low two address bits would make a non-word fetch.
  function automatic logic is_misaligned(input logic [N-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Address actually loaded into the PC for a redirect to addr.
  function automatic logic [N-1:0] redirect_address(input logic [N-1:0] addr);
`ifdef PC_ALIGN_CHECK_EN
    if (is_misaligned(addr)) begin
      return TRAP_VECTOR;
    end else begin
      return addr & ALIGN_MASK;
    end
`else
    return addr & ALIGN_MASK;
`endif
  endfunction

  logic [1:0]   state_r;
  logic [N-1:0] pc_r;
  logic         valid_r;
  logic [N-1:0] count_r;

  logic [1:0]   next_state_s;
  logic [N-1:0] next_pc_s;
  logic         next_valid_s;
  logic [N-1:0] next_count_s;
  logic         accept_s;
  logic [N-1:0] load_pc_s;

`ifdef PC_ALIGN_CHECK_EN
  logic         misalign_r;
  logic         next_misalign_s;
`endif

  // Handshake completes only when the request is live and downstream is not stalled.
  assign accept_s  = valid_r & ready & ~stall;
  assign load_pc_s = redirect_address(target);

  // Next-state, next-PC and next-count selection.
  always_comb begin
    next_state_s = state_r;
    next_pc_s    = pc_r;
    if (accept_s) begin
      next_count_s = count_r + COUNT_STEP;
    end else begin
      next_count_s = count_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (redirect) begin
          next_pc_s    = load_pc_s;
          next_state_s = ST_IDLE;
        end else if (enable) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Redirect wins over disable, which wins over the PC step.
        if (redirect) begin
          next_pc_s    = load_pc_s;
          next_state_s = ST_BUBBLE;
        end else if (!enable) begin
          next_state_s = ST_IDLE;
        end else if (accept_s) begin
          next_pc_s    = pc_r + PC_STEP;
          next_state_s = ST_FETCH;
        end else begin
          next_pc_s    = pc_r;
          next_state_s = ST_FETCH;
        end
      end
      ST_BUBBLE: begin
        // A further redirect replaces the pending target and keeps the bubble.
        if (redirect) begin
          next_pc_s    = load_pc_s;
          next_state_s = ST_BUBBLE;
        end else if (enable) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_pc_s    = pc_r;
      end
    endcase
    next_valid_s = (next_state_s == ST_FETCH);
  end

`ifdef PC_ALIGN_CHECK_EN
  // Any redirect to a misaligned target produces a trap pulse on the next cycle.
  always_comb begin
    if (redirect) begin
      next_misalign_s = is_misaligned(target);
    end else begin
      next_misalign_s = 1'b0;
    end
  end
`endif

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_VECTOR;
      valid_r <= 1'b0;
      count_r <= {N{1'b0}};
    end else begin
      state_r <= next_state_s;
      pc_r    <= next_pc_s;
      valid_r <= next_valid_s;
      count_r <= next_count_s;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Trap pulse register.
  always_ff @(posedge clock) begin
    if (reset) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= next_misalign_s;
    end
  end

  assign misalign = misalign_r;
`endif

  assign pc_out      = pc_r;
  assign valid       = valid_r;
  assign fetch_count = count_r;
  assign pc_plus4    = pc_r + PC_STEP;

  pc_fetch_checker #(.N(N)) u_checker (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .stall    (stall),
    .redirect (redirect),
    .ready    (ready),
    .valid    (valid_r),
    .pc_out   (pc_r)
  );

endmodule

// pc_fetch_checker: protocol properties of the fetch request.
module pc_fetch_checker #(
  parameter int N = 32
) (
  input logic         clock,
  input logic         reset,
  input logic         enable,
  input logic         stall,
  input logic         redirect,
  input logic         ready,
  input logic         valid,
  input logic [N-1:0] pc_out
);

  // A live request that is not accepted, redirected or dropped keeps its address.
  property p_hold_pc;
    @(posedge clock) disable iff (reset)
      (valid && !(ready && !stall) && !redirect && enable) |=> $stable(pc_out);
  endproperty
  a_hold_pc: assert property (p_hold_pc);

  // The fetch address is always word aligned when presented as live.
  property p_aligned;
    @(posedge clock) disable iff (reset) valid |-> (pc_out[1:0] == 2'b00);
  endproperty
  a_aligned: assert property (p_aligned);

endmodule
